// File: rtl/spu_wb_pkg.sv
// Shared constants, stage-entry type and latency clamp for the SPU result
// staging / write-back pipe.
package spu_wb_pkg;

    localparam int DEPTH   = 7;
    localparam int DATA_W  = 128;
    localparam int ADDR_W  = 7;
    localparam int LAT_W   = 3;
    localparam int NUM_FWD = 6;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rt;
        logic [DATA_W-1:0] data;
        logic [LAT_W-1:0]  lat;
    } wb_entry_t;

    // A zero latency still needs one stage to become visible; anything past the
    // pipe depth would never be ready before write-back.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        if (int'(lat) > DEPTH)
            return LAT_W'(DEPTH);
        return lat;
    endfunction

endpackage

// File: rtl/spu_wb_pipe_if.sv
// EX-result, register-file write and operand-forwarding signals of the SPU
// write-back pipe; master is the datapath side, slave is the pipe itself.
interface spu_wb_pipe_if;
    import spu_wb_pkg::*;

    logic                      flush;
    logic                      ex1_we;
    logic [ADDR_W-1:0]         ex1_rt;
    logic [DATA_W-1:0]         ex1_data;
    logic [LAT_W-1:0]          ex1_lat;
    logic                      ex2_we;
    logic [ADDR_W-1:0]         ex2_rt;
    logic [DATA_W-1:0]         ex2_data;
    logic [LAT_W-1:0]          ex2_lat;

    logic                      wb1_we;
    logic [ADDR_W-1:0]         wb1_rt;
    logic [DATA_W-1:0]         wb1_data;
    logic                      wb2_we;
    logic [ADDR_W-1:0]         wb2_rt;
    logic [DATA_W-1:0]         wb2_data;

    logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
    logic [NUM_FWD-1:0]        fwd_hit;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic [NUM_FWD-1:0]        fwd_stall;

    modport master (
        output flush, ex1_we, ex1_rt, ex1_data, ex1_lat,
               ex2_we, ex2_rt, ex2_data, ex2_lat, fwd_addr,
        input  wb1_we, wb1_rt, wb1_data, wb2_we, wb2_rt, wb2_data,
               fwd_hit, fwd_data, fwd_stall
    );

    modport slave (
        input  flush, ex1_we, ex1_rt, ex1_data, ex1_lat,
               ex2_we, ex2_rt, ex2_data, ex2_lat, fwd_addr,
        output wb1_we, wb1_rt, wb1_data, wb2_we, wb2_rt, wb2_data,
               fwd_hit, fwd_data, fwd_stall
    );

endinterface

// File: rtl/spu_wb_lane.sv
// One lane of the write-back pipe: a DEPTH-stage non-stalling shift pipe of
// result entries plus a per-stage "result is ready to forward" vector.
module spu_wb_lane
    import spu_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_rt,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [LAT_W-1:0]      i_lat,
    output wb_entry_t [DEPTH-1:0] o_stage,
    output logic [DEPTH-1:0]      o_ready
);

    wb_entry_t [DEPTH-1:0] r_stage;

    // NOTE: every field is reset, not just valid, because the write-back port
    // is the last stage itself and must read all-zero straight after reset.
    // NOTE: sequential state uses <= so each stage samples its neighbour's
    // pre-edge value and the whole pipe shifts by exactly one per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= '{valid: i_we, rt: i_rt, data: i_data, lat: clamp_lat(i_lat)};
            for (int i = 1; i < DEPTH; i++)
                r_stage[i] <= r_stage[i-1];
        end
    end

    // An entry in stage i has been in flight for i+1 cycles.
    always_comb begin
        o_ready = '0;
        for (int i = 0; i < DEPTH; i++)
            o_ready[i] = (i + 1) >= int'(r_stage[i].lat);
    end

    assign o_stage = r_stage;

endmodule

// File: rtl/spu_wb_pipe.sv
// SPU result staging / write-back pipe: two lane pipes, same-cycle WAW
// suppression and the operand-forwarding search (built with SPU_WB_FWD_EN).
module spu_wb_pipe
    import spu_wb_pkg::*;
(
    input logic          clk,
    input logic          reset,
    spu_wb_pipe_if.slave bus
);

    wb_entry_t [DEPTH-1:0]     w_stage1;
    wb_entry_t [DEPTH-1:0]     w_stage2;
    logic [DEPTH-1:0]          w_ready1;
    logic [DEPTH-1:0]          w_ready2;
    logic                      w_waw;
    logic [ADDR_W-1:0]         w_addr;
    logic [NUM_FWD-1:0]        w_fwd_hit;
    logic [NUM_FWD-1:0]        w_fwd_stall;
    logic [NUM_FWD*DATA_W-1:0] w_fwd_data;
    logic                      w_unused;

    spu_wb_lane u_lane1 (
        .clk     (clk),
        .reset   (reset),
        .i_we    (bus.ex1_we & ~bus.flush),
        .i_rt    (bus.ex1_rt),
        .i_data  (bus.ex1_data),
        .i_lat   (bus.ex1_lat),
        .o_stage (w_stage1),
        .o_ready (w_ready1)
    );

    spu_wb_lane u_lane2 (
        .clk     (clk),
        .reset   (reset),
        .i_we    (bus.ex2_we & ~bus.flush),
        .i_rt    (bus.ex2_rt),
        .i_data  (bus.ex2_data),
        .i_lat   (bus.ex2_lat),
        .o_stage (w_stage2),
        .o_ready (w_ready2)
    );

    // Lane 2 is younger in program order, so it owns a shared target.
    assign w_waw = w_stage1[DEPTH-1].valid && w_stage2[DEPTH-1].valid
                && (w_stage1[DEPTH-1].rt == w_stage2[DEPTH-1].rt);

    assign bus.wb1_we   = w_stage1[DEPTH-1].valid & ~w_waw;
    assign bus.wb1_rt   = w_stage1[DEPTH-1].rt;
    assign bus.wb1_data = w_stage1[DEPTH-1].data;
    assign bus.wb2_we   = w_stage2[DEPTH-1].valid;
    assign bus.wb2_rt   = w_stage2[DEPTH-1].rt;
    assign bus.wb2_data = w_stage2[DEPTH-1].data;

    // Walk oldest to youngest so the youngest match is the last one written.
    // NOTE: every output of this block gets a default first, otherwise a path
    // with no match would hold the old value and infer a latch.
    always_comb begin
        w_addr      = '0;
        w_fwd_hit   = '0;
        w_fwd_stall = '0;
        w_fwd_data  = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            w_addr = bus.fwd_addr[k*ADDR_W +: ADDR_W];
            for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef SPU_WB_FWD_EN
                if (w_stage1[i].valid && (w_stage1[i].rt == w_addr)) begin
                    w_fwd_hit[k]                   = w_ready1[i];
                    w_fwd_stall[k]                 = ~w_ready1[i];
                    w_fwd_data[k*DATA_W +: DATA_W] = w_ready1[i] ? w_stage1[i].data : '0;
                end
                if (w_stage2[i].valid && (w_stage2[i].rt == w_addr)) begin
                    w_fwd_hit[k]                   = w_ready2[i];
                    w_fwd_stall[k]                 = ~w_ready2[i];
                    w_fwd_data[k*DATA_W +: DATA_W] = w_ready2[i] ? w_stage2[i].data : '0;
                end
`else
                // Without forwarding, issue waits for write-back of any match.
                if ((w_stage1[i].valid && (w_stage1[i].rt == w_addr)) ||
                    (w_stage2[i].valid && (w_stage2[i].rt == w_addr)))
                    w_fwd_stall[k] = 1'b1;
`endif
            end
        end
    end

    assign bus.fwd_hit   = w_fwd_hit;
    assign bus.fwd_stall = w_fwd_stall;
    assign bus.fwd_data  = w_fwd_data;

    assign w_unused = ^{w_stage1, w_stage2, w_ready1, w_ready2};

endmodule

// File: doc/spu_wb_pipe.md
Name: spu_wb_pipe

Overview:
- Result staging and write-back pipeline for the dual-issue SPU datapath.
- Sits after the EX units (lane 1 even pipe, lane 2 odd pipe) and consumes their results, per-instruction latency and target register.
- Ages each result through a fixed-depth shift pipe, writes it to the register file at a uniform depth, and serves RA/RB/RC operand forwarding back to the REG->EX boundary.

Parameters:
- DEPTH, 7, stages per lane; write-back occurs from stage DEPTH-1.
- DATA_W, 128, result width.
- ADDR_W, 7, register address width (128 registers).
- LAT_W, 3, latency field width.
- NUM_FWD, 6, forwarding lookup ports (RA/RB/RC x 2 lanes).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill this cycle's lane inputs (branch mispredict)
- ex1_we  in  1  lane 1 result valid, writes register
- ex1_rt  in  ADDR_W  lane 1 target register
- ex1_data  in  DATA_W  lane 1 result
- ex1_lat  in  LAT_W  lane 1 unit latency, 1..DEPTH
- ex2_we, ex2_rt, ex2_data, ex2_lat  in  as lane 1, for lane 2
- wb1_we  out  1  lane 1 register-file write enable
- wb1_rt  out  ADDR_W  lane 1 write address
- wb1_data  out  DATA_W  lane 1 write data
- wb2_we, wb2_rt, wb2_data  out  as lane 1, for lane 2
- fwd_addr  in  NUM_FWD*ADDR_W  lookup addresses, port k at bits [k*ADDR_W +: ADDR_W]
- fwd_hit  out  NUM_FWD  ready in-flight value supplied
- fwd_data  out  NUM_FWD*DATA_W  forwarded value, valid when hit
- fwd_stall  out  NUM_FWD  youngest match not yet ready; issue must stall

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high.
- Reset: all stage valid bits are 0. wb*_we = 0, wb*_rt = 0, wb*_data = 0. fwd_hit = 0, fwd_stall = 0.
- Per-lane stage entry: {valid, rt, data, lat}.
- Insert:
  - At each clock edge, stage 0 of lane n loads {exn_we & ~flush, exn_rt, exn_data, clamp(exn_lat)}.
  - Stage i loads stage i-1 every cycle; the pipe never stalls.
  - clamp: lat 0 becomes 1; lat > DEPTH becomes DEPTH.
- Age and readiness: an entry in stage i has age i+1 and is ready when age >= lat.
- Write-back:
  - wbn_we/rt/data are driven directly from lane n stage DEPTH-1 (registered outputs).
  - A result presented at edge t appears on wb at cycle t+DEPTH.
- Same-cycle WAW at write-back: if both wb entries are valid with equal rt, wb1_we is forced to 0. Lane 2 is younger in program order and wins.
- Forwarding (combinational over stages 0..DEPTH-1):
  - Search order, youngest first: stage0 lane2, stage0 lane1, stage1 lane2, ..., stage DEPTH-1 lane1.
  - The first valid entry with rt == fwd_addr[k] decides the result.
  - If that entry is ready: fwd_hit = 1, fwd_data = its data, fwd_stall = 0.
  - If that entry is not ready: fwd_stall = 1, fwd_hit = 0. Older ready matches are ignored.
  - No match: hit = 0, stall = 0, fwd_data = 0.
  - No reads of the current-cycle ex* inputs; the register file covers values already written.
- flush: gates only the current-cycle inputs. Entries already in flight are older and complete normally.
- Reset mid-operation: all in-flight entries are discarded and no write-back occurs afterwards.

Optional Feature:
- SPU_WB_FWD_EN defined:
  - Forwarding behaves as above.
- SPU_WB_FWD_EN undefined:
  - The forwarding network is not built.
  - fwd_hit = 0 and fwd_data = 0 always.
  - fwd_stall[k] = 1 whenever any valid entry in any stage matches fwd_addr[k], regardless of readiness; issue waits for write-back.

Decomposition:
- Package spu_wb_pkg:
  - Constants: DEPTH, DATA_W, ADDR_W, LAT_W.
  - typedef struct wb_entry_t {valid, rt, data, lat}.
  - function clamp_lat.
- Sub-module spu_wb_lane: one lane's DEPTH-stage shift pipe plus per-stage ready vector, instantiated twice.
- Top level: WAW suppression and the forwarding priority search.

Test Plan:
- Single result:
  - Stimulus: ex1_we = 1, rt = 5, data = 0xA5..A5, lat = 2 at edge 0.
  - Response: fwd_addr = 5 gives stall in cycle 1, then hit with 0xA5..A5 in cycles 2..7. wb1_we = 1, rt = 5 in cycle 7, and 0 in cycle 8.
- Latency clamp:
  - Stimulus: lat = 0, rt = 9, data = 0x1.
  - Response: hit at cycle 1. A separate lat = 7, rt = 10 entry stalls in cycles 1..6 and hits in cycle 7, the same cycle as write-back.
- Youngest wins:
  - Stimulus: rt = 3, data = 0x11, lat = 1 at edge 0; rt = 3, data = 0x22, lat = 4 at edge 2.
  - Response: cycle 3 shows stall, not 0x11. Cycle 6 shows hit with 0x22.
- Dual-lane WAW:
  - Stimulus: at the same edge, ex1 rt = 7 data = 0x1 and ex2 rt = 7 data = 0x2.
  - Response: cycle 7 shows wb1_we = 0, wb2_we = 1, wb2_data = 0x2. Forwarding returns 0x2.
- Flush and reset:
  - Stimulus: flush = 1 with ex2_we = 1, rt = 12.
  - Response: no stall, hit or write-back for rt = 12 ever. Reset asserted at cycle 3 with entries in flight leaves all wb_we = 0 through cycle 10.
- Without SPU_WB_FWD_EN:
  - Stimulus: scenario 1 replayed.
  - Response: stall in cycles 1..7, fwd_hit = 0 throughout.
